bus_arbiter_2to1: RTL and testbench
===================================

// Module: bus_arbiter_2to1
// PURPOSE
//   Round-robin arbiter sharing one W-bit output bus between two requesters.
//   Holds the grant in a registered FSM and drives the word-wide 2:1 select
//   from it. Provides per-requester acks and a valid/ready handshake to the
//   single downstream consumer (ALU/memory write port).
// PARAMETERS
//   W         16  data width of each requester and of the output bus
//   MAX_LOCK  4   max consecutive locked transfers before a waiting peer wins (ARB_LOCK_EN only)
// PORTS
//   clk        in   1  single clock, rising edge
//   rst        in   1  synchronous reset, active-high
//   req0       in   1  requester 0 has a word; held high with data0 stable until ack0
//   data0      in   W  requester 0 word
//   req1       in   1  requester 1 has a word; same rules as req0
//   data1      in   W  requester 1 word
//   ack0       out  1  word from requester 0 accepted this cycle
//   ack1       out  1  word from requester 1 accepted this cycle
//   out_valid  out  1  out_data holds a word for the consumer
//   out_data   out  W  selected word; 0 when out_valid=0
//   out_ready  in   1  consumer accepts the word this cycle
//   lock0/1    in   1  keep grant after transfer (present only with ARB_LOCK_EN)
// BEHAVIOUR
//   One clock, reset synchronous and active-high.
//   Reset: state=IDLE, sel=0, last=1 (req0 wins first tie), lock_cnt=0;
//   ack0=ack1=out_valid=0, out_data=0. Reset mid-transfer aborts; no ack is issued.
//   States: IDLE, GNT0, GNT1 (registered); sel=1 only in GNT1.
//   IDLE: single req -> GNTx next cycle; both -> GNT of requester != last.
//   GNTx: out_valid=reqx; out_data=datax; ackx=reqx & out_ready (combinational).
//   Transfer (ackx=1): last<=x; next=GNT of the other if its req=1, else IDLE.
//   GNTx with reqx=0 (possible only after a lock): IDLE next cycle, no ack.
//   Stall: out_ready=0 -> state, sel, out_data held; no ack.
//   Latency: req rise in IDLE -> out_valid next cycle. Both req continuously
//   with out_ready=1 -> alternating acks every cycle, no bubble.
//   Single requester back-to-back -> one IDLE bubble between words.
//   Never ack0 & ack1 in the same cycle; at most one ack per cycle.
// CONFIGURATION
//   Macro ARB_LOCK_EN.
//   Defined: lock0/lock1 ports exist. Transfer in GNTx with lockx=1 -> stay GNTx.
//   lock_cnt increments per locked transfer and clears on any grant change.
//   When lock_cnt reaches MAX_LOCK-1 and the other req=1, lock is ignored and the
//   other is granted. When the other req=0, lock is honoured indefinitely.
//   Not defined: no lock ports, no lock_cnt; behaviour exactly as above.
// STRUCTURE
//   Package arb_pkg: state typedef (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) and default W.
//   Sub-module bus_mux2: W-bit 2:1 word mux, sel ? data1 : data0. Output gated by out_valid.
//   FSM, last pointer and lock counter live in the top.
// TESTING
//   1 rst=1 with req0=1, out_ready=1 -> all outputs 0; 1st cycle after rst drops: IDLE; next: out_valid=1, out_data=data0.
//   2 req0=1 data0=16'h00AA, out_ready=1 -> ack0 one cycle after grant; out_data=16'h00AA in that cycle.
//   3 req0=req1=1 held, out_ready=1 for 6 cycles -> grant 0,1,0,1,0 with ack each cycle; data matches.
//   4 GNT1 with out_ready=0 for 3 cycles -> out_valid=1, out_data=data1 stable, no ack; 4th cycle out_ready=1 -> ack1.
//   5 Both req, out_ready=1, rst=1 pulse mid-stream -> next cycle IDLE, no acks; after release req0 wins tie.
//   6 ARB_LOCK_EN, lock0=1, req0 and req1 held, MAX_LOCK=4 -> 4 consecutive ack0, then ack1.
//     Without the macro the same stimulus alternates.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and defaults for the two-requester bus arbiter.
// The lock feature in the top is built only when ARB_LOCK_EN is defined.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam int W_DEFAULT        = 16;
    localparam int MAX_LOCK_DEFAULT = 4;

endpackage

// File: rtl/bus_mux2.sv
// W-bit 2:1 word select for the arbiter output bus.
// Output is forced to zero whenever no word is being presented.
module bus_mux2
    import arb_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         i_sel,
    input  logic         i_valid,
    input  logic [W-1:0] i_data0,
    input  logic [W-1:0] i_data1,
    output logic [W-1:0] o_data
);

    assign o_data = i_valid ? (i_sel ? i_data1 : i_data0) : '0;

endmodule

// File: rtl/bus_arbiter_2to1.sv
// Round-robin 2:1 bus arbiter with valid/ready downstream handshake.
// Define ARB_LOCK_EN to add lock0/lock1 inputs and the bounded lock counter.
//
// state | meaning
// IDLE  | no grant held; pick requester next cycle (tie goes to != last)
// GNT0  | requester 0 owns the bus
// GNT1  | requester 1 owns the bus
module bus_arbiter_2to1
    import arb_pkg::*;
#(
    parameter int W = W_DEFAULT
`ifdef ARB_LOCK_EN
    ,
    parameter int MAX_LOCK = MAX_LOCK_DEFAULT
`endif
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req0,
    input  logic [W-1:0] i_data0,
    input  logic         i_req1,
    input  logic [W-1:0] i_data1,
`ifdef ARB_LOCK_EN
    input  logic         i_lock0,
    input  logic         i_lock1,
`endif
    output logic         o_ack0,
    output logic         o_ack1,
    output logic         o_out_valid,
    output logic [W-1:0] o_out_data,
    input  logic         i_out_ready
);

    state_t r_state;
    state_t w_next;
    logic   r_last;
    logic   w_last_next;
    logic   w_ack0;
    logic   w_ack1;
    logic   w_valid;
    logic   w_sel;

`ifdef ARB_LOCK_EN
    localparam int LCW = $clog2(MAX_LOCK) + 1;
    localparam logic [LCW-1:0] LOCK_LIMIT = LCW'(MAX_LOCK - 1);

    logic [LCW-1:0] r_lock_cnt;
    logic [LCW-1:0] w_lock_cnt_next;
`endif

    always_comb begin
        w_next      = r_state;
        w_last_next = r_last;
        w_valid     = 1'b0;
        w_ack0      = 1'b0;
        w_ack1      = 1'b0;
`ifdef ARB_LOCK_EN
        w_lock_cnt_next = r_lock_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (i_req0 && i_req1)
                    w_next = r_last ? GNT0 : GNT1;
                else if (i_req0)
                    w_next = GNT0;
                else if (i_req1)
                    w_next = GNT1;
            end
            GNT0: begin
                w_valid = i_req0;
                w_ack0  = i_req0 & i_out_ready;
                if (!i_req0) begin
                    w_next = IDLE;
                end else if (w_ack0) begin
                    w_last_next = 1'b0;
                    w_next      = i_req1 ? GNT1 : IDLE;
`ifdef ARB_LOCK_EN
                    // A waiting peer overrides the lock once the streak hits the limit.
                    if (i_lock0 && !((r_lock_cnt == LOCK_LIMIT) && i_req1)) begin
                        w_next = GNT0;
                        if (r_lock_cnt != LOCK_LIMIT)
                            w_lock_cnt_next = r_lock_cnt + 1'b1;
                    end
`endif
                end
            end
            GNT1: begin
                w_valid = i_req1;
                w_ack1  = i_req1 & i_out_ready;
                if (!i_req1) begin
                    w_next = IDLE;
                end else if (w_ack1) begin
                    w_last_next = 1'b1;
                    w_next      = i_req0 ? GNT0 : IDLE;
`ifdef ARB_LOCK_EN
                    if (i_lock1 && !((r_lock_cnt == LOCK_LIMIT) && i_req0)) begin
                        w_next = GNT1;
                        if (r_lock_cnt != LOCK_LIMIT)
                            w_lock_cnt_next = r_lock_cnt + 1'b1;
                    end
`endif
                end
            end
            default: w_next = IDLE;
        endcase
`ifdef ARB_LOCK_EN
        if (w_next != r_state)
            w_lock_cnt_next = '0;
`endif
        // Reset aborts the current transfer in the same cycle it is asserted.
        if (i_rst) begin
            w_valid = 1'b0;
            w_ack0  = 1'b0;
            w_ack1  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
`ifdef ARB_LOCK_EN
            r_lock_cnt <= '0;
`endif
        end else begin
            r_state <= w_next;
            r_last  <= w_last_next;
`ifdef ARB_LOCK_EN
            r_lock_cnt <= w_lock_cnt_next;
`endif
        end
    end

    assign w_sel       = (r_state == GNT1);
    assign o_ack0      = w_ack0;
    assign o_ack1      = w_ack1;
    assign o_out_valid = w_valid;

    bus_mux2 #(.W(W)) u_mux (
        .i_sel   (w_sel),
        .i_valid (w_valid),
        .i_data0 (i_data0),
        .i_data1 (i_data1),
        .o_data  (o_out_data)
    );

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Bench for bus_arbiter_2to1: per-cycle model compare plus directed literal checks.
// Lock scenario expectations follow ARB_LOCK_EN when it is defined.
module tb_bus_arbiter_2to1;

    localparam int W        = 16;
    localparam int MAX_LOCK = 4;
`ifdef ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0;
    logic         req1 = 1'b0;
    logic         lock0 = 1'b0;
    logic         lock1 = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] data0 = '0;
    logic [W-1:0] data1 = '0;
    logic         ack0;
    logic         ack1;
    logic         out_valid;
    logic [W-1:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_arbiter_2to1 #(.W(W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req0      (req0),
        .i_data0     (data0),
        .i_req1      (req1),
        .i_data1     (data1),
`ifdef ARB_LOCK_EN
        .i_lock0     (lock0),
        .i_lock1     (lock1),
`endif
        .o_ack0      (ack0),
        .o_ack1      (ack1),
        .o_out_valid (out_valid),
        .o_out_data  (out_data),
        .i_out_ready (out_ready)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the bus (-1 none), who was served last, length of lock streak.
    int   m_gnt  = -1;
    int   m_last = 1;
    int   m_lock = 0;
    int   m_nxt;
    logic m_mine;
    logic m_other;
    logic m_lk;

    always @(posedge clk) begin
        if (rst) begin
            m_gnt  = -1;
            m_last = 1;
            m_lock = 0;
        end else begin
            if (m_gnt < 0) begin
                if (req0 && req1)  m_nxt = 1 - m_last;
                else if (req0)     m_nxt = 0;
                else if (req1)     m_nxt = 1;
                else               m_nxt = -1;
            end else begin
                m_mine  = (m_gnt == 0) ? req0 : req1;
                m_other = (m_gnt == 0) ? req1 : req0;
                m_lk    = LOCK_EN && ((m_gnt == 0) ? lock0 : lock1);
                if (!m_mine) begin
                    m_nxt = -1;
                end else if (out_ready) begin
                    m_last = m_gnt;
                    if (m_lk && !(m_lock >= MAX_LOCK - 1 && m_other)) begin
                        m_nxt = m_gnt;
                        if (m_lock < MAX_LOCK - 1) m_lock++;
                    end else begin
                        m_nxt = m_other ? 1 - m_gnt : -1;
                    end
                end else begin
                    m_nxt = m_gnt;
                end
            end
            if (m_nxt != m_gnt) m_lock = 0;
            m_gnt = m_nxt;
        end
    end

    logic         e_valid;
    logic         e_ack0;
    logic         e_ack1;
    logic [W-1:0] e_data;

    always @(negedge clk) begin
        e_valid = !rst && ((m_gnt == 0 && req0) || (m_gnt == 1 && req1));
        e_data  = e_valid ? ((m_gnt == 0) ? data0 : data1) : '0;
        e_ack0  = !rst && (m_gnt == 0) && req0 && out_ready;
        e_ack1  = !rst && (m_gnt == 1) && req1 && out_ready;
        check1("model_valid", out_valid, e_valid);
        checkw("model_data", out_data, e_data);
        check1("model_ack0", ack0, e_ack0);
        check1("model_ack1", ack1, e_ack1);
        check1("single_ack", ack0 & ack1, 1'b0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic exp_a0;

    initial begin
        // 1: reset with a pending request, then first grant
        data0 = 16'h1234; req0 = 1'b1; out_ready = 1'b1; rst = 1'b1;
        repeat (2) step();
        @(negedge clk);
        check1("t1_rst_valid", out_valid, 1'b0);
        check1("t1_rst_ack0", ack0, 1'b0);
        checkw("t1_rst_data", out_data, 16'h0000);
        step(); rst = 1'b0;
        @(negedge clk);
        check1("t1_idle_valid", out_valid, 1'b0);
        step();
        @(negedge clk);
        check1("t1_gnt_valid", out_valid, 1'b1);
        checkw("t1_gnt_data", out_data, 16'h1234);
        check1("t1_gnt_ack0", ack0, 1'b1);
        step(); req0 = 1'b0;
        @(negedge clk);
        check1("t1_after_valid", out_valid, 1'b0);

        // 2: single word
        step(); req0 = 1'b1; data0 = 16'h00AA;
        @(negedge clk);
        check1("t2_idle_valid", out_valid, 1'b0);
        step();
        @(negedge clk);
        check1("t2_ack0", ack0, 1'b1);
        checkw("t2_data", out_data, 16'h00AA);
        step(); req0 = 1'b0;

        // 3: both requesting, alternating with no bubble
        rst = 1'b1;
        step();
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1; data0 = 16'hA0A0; data1 = 16'hB1B1;
        @(negedge clk);
        check1("t3_idle_valid", out_valid, 1'b0);
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check1("t3_ack0", ack0, (k % 2) == 0);
            check1("t3_ack1", ack1, (k % 2) == 1);
            checkw("t3_data", out_data, ((k % 2) == 0) ? 16'hA0A0 : 16'hB1B1);
            step();
        end

        // 4: stall in GNT1
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check1("t4_stall_valid", out_valid, 1'b1);
            checkw("t4_stall_data", out_data, 16'hB1B1);
            check1("t4_stall_ack1", ack1, 1'b0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check1("t4_release_ack1", ack1, 1'b1);
        step();

        // 5: reset pulse mid-stream
        @(negedge clk);
        check1("t5_pre_ack0", ack0, 1'b1);
        step(); rst = 1'b1;
        @(negedge clk);
        check1("t5_rst_ack1", ack1, 1'b0);
        check1("t5_rst_valid", out_valid, 1'b0);
        step(); rst = 1'b0;
        @(negedge clk);
        check1("t5_idle_valid", out_valid, 1'b0);
        step();
        @(negedge clk);
        check1("t5_tie_ack0", ack0, 1'b1);
        check1("t5_tie_ack1", ack1, 1'b0);
        checkw("t5_tie_data", out_data, 16'hA0A0);

        // 6: lock0 held with both requesting
        step(); rst = 1'b1; lock0 = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        check1("t6_idle_valid", out_valid, 1'b0);
        step();
        for (int k = 0; k < 5; k++) begin
            exp_a0 = LOCK_EN ? (k < 4) : ((k % 2) == 0);
            @(negedge clk);
            check1("t6_ack0", ack0, exp_a0);
            check1("t6_ack1", ack1, !exp_a0);
            step();
        end

        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
